// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and helpers for serial_subtractor
package serial_sub_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
   function automatic int clog2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/serial_subtractor_fs_digit.sv
// fs_digit: ripple chain of DIGIT_W full-subtractor cells
module fs_digit #(parameter int DIGIT_W = 1) (
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   input  logic               bi,
   output logic [DIGIT_W-1:0] d,
   output logic               bo
);
   logic [DIGIT_W:0] c;
   assign c[0] = bi;
   for (genvar i = 0; i < DIGIT_W; i++) begin : g_cell
      assign d[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c[i]);
   end
   assign bo = c[DIGIT_W];
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial a - b - bin, LSB digit first, with start/busy/done handshake
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DIGIT_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);
   localparam int NDIG = WIDTH / DIGIT_W;
   localparam int CW = clog2(NDIG) < 1 ? 1 : clog2(NDIG);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
   if (WIDTH < 2 || DIGIT_W < 1 || WIDTH % DIGIT_W != 0) begin : g_bad_params
      $error("serial_subtractor: DIGIT_W must divide WIDTH and WIDTH must be >= 2");
   end
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] sa, sb;
   logic br, am, bm, acc, bo;
   logic [DIGIT_W-1:0] d;
   fs_digit #(.DIGIT_W(DIGIT_W)) u_fs (
      .x(sa[DIGIT_W-1:0]), .y(sb[DIGIT_W-1:0]), .bi(br), .d(d), .bo(bo)
   );
   assign acc  = start && (state == ST_IDLE || state == ST_DONE);
   assign busy = state == ST_BUSY;
   assign done = state == ST_DONE;
   always_comb begin
      nxt = state == ST_BUSY ? (cnt == LAST ? ST_DONE : ST_BUSY) : acc ? ST_BUSY : ST_IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else state <= nxt;
   end
   // operand MSBs are kept apart because the shift registers lose them during BUSY
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa <= '0;
         sb <= '0;
         br <= 1'b0;
         cnt <= '0;
         am <= 1'b0;
         bm <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
         ovf <= 1'b0;
      end else if (acc) begin
         sa <= a;
         sb <= b;
         br <= bin;
         cnt <= '0;
         am <= a[WIDTH-1];
         bm <= b[WIDTH-1];
      end else if (state == ST_BUSY) begin
         sa <= sa >> DIGIT_W;
         sb <= sb >> DIGIT_W;
         br <= bo;
         cnt <= cnt + 1'b1;
         diff <= WIDTH'({d, diff} >> DIGIT_W);
         if (cnt == LAST) begin
            bout <= bo;
            ovf <= (am != bm) && (d[DIGIT_W-1] != am);
         end
      end
   end
endmodule
